// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//   Issue/sequencing stage in front of the 32-bit CLA ALU (alu32). Takes one
//   op request over valid/ready, latches it, decodes the 4-bit ALU-control code
//   into alu32 control drive, captures the ALU result/cout/V and presents a
//   registered result plus flags over valid/ready.
//
//   SLT is resolved in two passes so alu32 never sees a combinational loop
//   from its own set output back into less: a SUB pass computes
//   set = sum[MSB] ^ V, then a second pass drives less = set.
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   in_valid/in_ready             request handshake; in_op/in_a/in_b payload
//   alu_src1/alu_src2             operands to alu32
//   alu_a_inv/alu_b_inv/alu_cin   alu32 A_invert / B_invert / cin
//   alu_op/alu_less               alu32 operation select / less input
//   alu_result/alu_cout/alu_v     results from alu32
//   out_valid/out_ready           result handshake
//   out_res                       registered result
//   out_cout/out_ovf              carry / signed overflow (ADD and SUB only)
//   out_zero/out_err              result==0 / illegal opcode
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] alu_src1,
    output logic [WIDTH-1:0] alu_src2,
    output logic             alu_a_inv,
    output logic             alu_b_inv,
    output logic             alu_cin,
    output logic             alu_less,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    input  logic             alu_v,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_err
);

    localparam logic [OPW-1:0] OP_AND = OPW'(4'b0000);
    localparam logic [OPW-1:0] OP_OR  = OPW'(4'b0001);
    localparam logic [OPW-1:0] OP_ADD = OPW'(4'b0010);
    localparam logic [OPW-1:0] OP_SUB = OPW'(4'b0110);
    localparam logic [OPW-1:0] OP_SLT = OPW'(4'b0111);
    localparam logic [OPW-1:0] OP_NOR = OPW'(4'b1100);

    typedef enum logic [2:0] {IDLE, EXEC, SLT_CMP, SLT_SET, HOLD} state_t;

    typedef struct packed {
        logic       a_inv;
        logic       b_inv;
        logic       cin;
        logic [1:0] op;
    } ctl_t;

    state_t           state, state_nx;
    logic [OPW-1:0]   op_r;
    logic [WIDTH-1:0] a_r, b_r;
    logic             set_r;
    logic [WIDTH-1:0] res_r;
    logic             cout_r, ovf_r, zero_r, err_r;
    ctl_t             ctl;

    function automatic logic op_legal(input logic [OPW-1:0] op);
        return (op == OP_AND) || (op == OP_OR)  || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT) || (op == OP_NOR);
    endfunction

    // Non-SLT decode; SLT drive is produced directly by its two pass states.
    function automatic ctl_t decode(input logic [OPW-1:0] op);
        ctl_t c;
        c = '0;
        case (op)
            OP_AND:  c = '{a_inv: 1'b0, b_inv: 1'b0, cin: 1'b0, op: 2'b00};
            OP_OR:   c = '{a_inv: 1'b0, b_inv: 1'b0, cin: 1'b0, op: 2'b01};
            OP_ADD:  c = '{a_inv: 1'b0, b_inv: 1'b0, cin: 1'b0, op: 2'b10};
            OP_SUB:  c = '{a_inv: 1'b0, b_inv: 1'b1, cin: 1'b1, op: 2'b10};
            OP_NOR:  c = '{a_inv: 1'b1, b_inv: 1'b1, cin: 1'b0, op: 2'b00};
            default: c = '0;
        endcase
        return c;
    endfunction

    assign ctl       = decode(op_r);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);
    assign out_res   = res_r;
    assign out_cout  = cout_r;
    assign out_ovf   = ovf_r;
    assign out_zero  = zero_r;
    assign out_err   = err_r;

    always_comb begin
        state_nx  = state;
        alu_src1  = '0;
        alu_src2  = '0;
        alu_a_inv = 1'b0;
        alu_b_inv = 1'b0;
        alu_cin   = 1'b0;
        alu_less  = 1'b0;
        alu_op    = 2'b00;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (!op_legal(in_op))     state_nx = HOLD;
                    else if (in_op == OP_SLT) state_nx = SLT_CMP;
                    else                      state_nx = EXEC;
                end
            end
            EXEC: begin
                alu_src1  = a_r;
                alu_src2  = b_r;
                alu_a_inv = ctl.a_inv;
                alu_b_inv = ctl.b_inv;
                alu_cin   = ctl.cin;
                alu_op    = ctl.op;
                state_nx  = HOLD;
            end
            SLT_CMP: begin
                alu_src1  = a_r;
                alu_src2  = b_r;
                alu_b_inv = 1'b1;
                alu_cin   = 1'b1;
                alu_op    = 2'b10;
                state_nx  = SLT_SET;
            end
            SLT_SET: begin
                alu_src1  = a_r;
                alu_src2  = b_r;
                alu_b_inv = 1'b1;
                alu_cin   = 1'b1;
                alu_op    = 2'b11;
                alu_less  = set_r;
                state_nx  = HOLD;
            end
            HOLD: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            set_r  <= 1'b0;
            res_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                // accept: latch request; illegal codes complete immediately
                IDLE: begin
                    if (in_valid) begin
                        op_r <= in_op;
                        a_r  <= in_a;
                        b_r  <= in_b;
                        if (!op_legal(in_op)) begin
                            res_r  <= '0;
                            cout_r <= 1'b0;
                            ovf_r  <= 1'b0;
                            zero_r <= 1'b1;
                            err_r  <= 1'b1;
                        end
                    end
                end
                // single-pass capture; carry/overflow only meaningful for ADD/SUB
                EXEC: begin
                    res_r  <= alu_result;
                    cout_r <= ((op_r == OP_ADD) || (op_r == OP_SUB)) & alu_cout;
                    ovf_r  <= ((op_r == OP_ADD) || (op_r == OP_SUB)) & alu_v;
                    zero_r <= (alu_result == '0);
                    err_r  <= 1'b0;
                end
                // SLT pass 1: signed less-than is sign of difference corrected by V
                SLT_CMP: begin
                    set_r <= alu_result[WIDTH-1] ^ alu_v;
                end
                // SLT pass 2: alu32 returns less in bit 0
                SLT_SET: begin
                    res_r  <= alu_result;
                    cout_r <= 1'b0;
                    ovf_r  <= 1'b0;
                    zero_r <= (alu_result == '0);
                    err_r  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a, in_b;
    logic [31:0] alu_src1, alu_src2;
    logic        alu_a_inv, alu_b_inv, alu_cin, alu_less;
    logic [1:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_cout, alu_v;
    logic        out_valid, out_ready;
    logic [31:0] out_res;
    logic        out_cout, out_ovf, out_zero, out_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(32), .OPW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_a_inv(alu_a_inv), .alu_b_inv(alu_b_inv), .alu_cin(alu_cin),
        .alu_less(alu_less), .alu_op(alu_op),
        .alu_result(alu_result), .alu_cout(alu_cout), .alu_v(alu_v),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero), .out_err(out_err)
    );

    // Behavioural stand-in for alu32 (the environment the sequencer drives).
    logic [31:0] ea, eb;
    logic [32:0] esum;
    always_comb begin
        ea   = alu_a_inv ? ~alu_src1 : alu_src1;
        eb   = alu_b_inv ? ~alu_src2 : alu_src2;
        esum = {1'b0, ea} + {1'b0, eb} + {32'b0, alu_cin};
        alu_cout = esum[32];
        alu_v    = (ea[31] == eb[31]) && (esum[31] != ea[31]);
        case (alu_op)
            2'b00:   alu_result = ea & eb;
            2'b01:   alu_result = ea | eb;
            2'b10:   alu_result = esum[31:0];
            default: alu_result = {31'b0, alu_less};
        endcase
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        err;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: what the operation means arithmetically, independent of alu32 controls.
    function automatic vec_t ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        vec_t   e;
        longint sa, sb, s;
        logic [32:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.op = op; e.a = a; e.b = b;
        e.res = 0; e.cout = 0; e.ovf = 0; e.err = 0; e.lat = 2;
        case (op)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b1100: e.res = ~(a | b);
            4'b0010: begin
                u = {1'b0, a} + {1'b0, b};
                s = sa + sb;
                e.res = u[31:0]; e.cout = u[32];
                e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110: begin
                s = sa - sb;
                e.res = a - b; e.cout = (a >= b);
                e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0111: begin
                e.res = (sa < sb) ? 32'd1 : 32'd0;
                e.lat = 3;
            end
            default: begin
                e.err = 1; e.lat = 1;
            end
        endcase
        e.zero = (e.res == 0);
        return e;
    endfunction

    // Present a request, wait for acceptance, then count to out_valid.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic ordy, output int lat);
        int n;
        @(negedge clk);
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1; out_ready = ordy;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op = 4'($urandom); in_a = $urandom; in_b = $urandom;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        chk({tag, "_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    task automatic check_out(input string tag, input vec_t e, input int lat);
        chk({tag, "_lat"},  64'(lat), 64'(e.lat));
        chk({tag, "_res"},  64'(out_res), 64'(e.res));
        chk({tag, "_flags"}, {60'b0, out_cout, out_ovf, out_zero, out_err},
                             {60'b0, e.cout, e.ovf, e.zero, e.err});
        chk({tag, "_busy"}, 64'(in_ready), 64'd0);
    endtask

    task automatic check_idle_drives(input string tag);
        chk({tag, "_src"}, {alu_src1, alu_src2}, 64'd0);
        chk({tag, "_ctl"}, {58'b0, alu_a_inv, alu_b_inv, alu_cin, alu_less, alu_op}, 64'd0);
    endtask

    vec_t tbl[9];
    logic [3:0] legal_ops[6];

    initial begin
        int   lat;
        vec_t e;
        logic [3:0]  op;
        logic [31:0] a, b;

        legal_ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
        //            op       a             b             res           c  v  z  e  lat
        tbl[0] = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0, 2};
        tbl[1] = '{4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 2};
        tbl[2] = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        tbl[3] = '{4'b0111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        tbl[4] = '{4'b0111, 32'h00000003, 32'h00000002, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 3};
        tbl[5] = '{4'b1100, 32'h0F0F0000, 32'h00F00F00, 32'hF000F0FF, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        tbl[6] = '{4'b0101, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 1};
        tbl[7] = '{4'b0000, 32'hF0F0FFFF, 32'h0FF0F00F, 32'h00F0F00F, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        tbl[8] = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 2};

        rst_n = 1'b0; in_valid = 1'b0; in_op = 0; in_a = 0; in_b = 0; out_ready = 1'b0;
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_outputs", {27'b0, out_res, out_cout, out_ovf, out_zero, out_err, 1'b0}, 64'd0);
        check_idle_drives("rst");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, lat);
            check_out($sformatf("vec%0d", i), tbl[i], lat);
            retire($sformatf("vec%0d", i));
        end

        // Consumer stalls for 5 cycles in HOLD.
        issue(4'b0010, 32'd10, 32'd20, 1'b0, lat);
        chk("stall_lat", 64'(lat), 64'd2);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d_valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("stall%0d_res", k), 64'(out_res), 64'd30);
            chk($sformatf("stall%0d_busy", k), 64'(in_ready), 64'd0);
        end
        retire("stall");

        // Reset lands while the SLT second pass is being driven.
        @(negedge clk);
        in_op = 4'b0111; in_a = 32'hFFFFFFFF; in_b = 32'd1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("midslt_less_driven", 64'(alu_less), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midslt_rst_valid", 64'(out_valid), 64'd0);
        chk("midslt_rst_ready", 64'(in_ready), 64'd1);
        check_idle_drives("midslt_rst");
        @(negedge clk);
        rst_n = 1'b1;
        issue(4'b0010, 32'd1, 32'd2, 1'b0, lat);
        check_out("post_rst_add", ref_model(4'b0010, 32'd1, 32'd2), lat);
        retire("post_rst_add");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = 4'($urandom); while (op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100});
            end else begin
                op = legal_ops[$urandom_range(0, 5)];
            end
            case ($urandom_range(0, 3))
                0:       a = 32'h80000000 ^ 32'($urandom_range(0, 3));
                1:       a = 32'h7FFFFFFF - 32'($urandom_range(0, 3));
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 4) == 0) ? a : $urandom;
            e = ref_model(op, a, b);
            issue(op, a, b, 1'($urandom_range(0, 1)), lat);
            check_out($sformatf("rnd%0d_op%0h", i, op), e, lat);
            retire($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
